// File: rtl/chr_rom_pkg.sv
// Shared types and helpers for the character ROM arbiter.
// Holds lane-select width, default data width, slot tag record and CHDT slicing.
package chr_rom_pkg;

    // Default word width for the default build (LANES=4).
    localparam int DW = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int dw_of(input int lanes);
        return 8 * lanes;
    endfunction

    // Low bit of channel c's slice within a packed CHDT bus.
    function automatic int chdt_lo(input int c, input int dw);
        return c * dw;
    endfunction

    // Lookup tag travelling alongside the ROM read data.
    typedef struct packed {
        logic       vld;
        logic [2:0] ch;
    } tag_t;

endpackage

// File: rtl/chr_rom_arbiter_if.sv
// Client/loader bundle for the character ROM arbiter.
// master: fetch units + loader (drive CHREQ/CHAD/ROM*); slave: arbiter.
interface chr_rom_arbiter_if #(
    parameter int NCH   = 2,
    parameter int AW    = 14,
    parameter int LANES = 4,
    parameter int SB    = 1
);
    localparam int DWI = 8 * LANES;
    localparam int LB  = chr_rom_pkg::clog2(LANES);

    logic [NCH-1:0]     CHREQ;
    logic [NCH*AW-1:0]  CHAD;
    logic [NCH-1:0]     CHGNT;
    logic [NCH*DWI-1:0] CHDT;
    logic [NCH-1:0]     CHVAL;
    logic [SB-1:0]      PHASE;
    logic               ROMEN;
    logic [AW+LB-1:0]   ROMAD;
    logic [7:0]         ROMDT;

    modport master (
        output CHREQ, CHAD, ROMEN, ROMAD, ROMDT,
        input  CHGNT, CHDT, CHVAL, PHASE
    );

    modport slave (
        input  CHREQ, CHAD, ROMEN, ROMAD, ROMDT,
        output CHGNT, CHDT, CHVAL, PHASE
    );
endinterface

// File: rtl/chr_rom_lane.sv
// One byte lane of the character ROM: simple dual-port RAM, registered read.
// Ports: clk, we/waddr/wdata (download), raddr (lookup), rdata (next-cycle data).
module chr_rom_lane #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Read samples the array before this edge's write lands: old data wins.
    always_comb rdata_d = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/chr_rom_arbiter.sv
// NCH-client character ROM share: slot arbiter, LANES-wide ROM, 2-cycle read pipe.
// Ports: CLK, RESET (sync, active-high), bus (slave side of chr_rom_arbiter_if).
// Define ROMARB_SKIP_IDLE_EN for work-conserving round-robin instead of fixed TDM.
module chr_rom_arbiter
    import chr_rom_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = 14,
    parameter int LANES = 4,
    parameter int SB    = 1
) (
    input logic              CLK,
    input logic              RESET,
    chr_rom_arbiter_if.slave bus
);
    localparam int DWL = dw_of(LANES);
    localparam int LB  = clog2(LANES);
    localparam int RAW = AW + LB;

    logic               gnt_any;
    logic [SB-1:0]      sel;
    logic [NCH-1:0]     gnt;
    logic [AW-1:0]      raddr;
    logic [DWL-1:0]     rd;
    tag_t               tag_q, tag_d;
    logic [NCH-1:0]     val_q, val_d;
    logic [NCH*DWL-1:0] dt_q, dt_d;

`ifdef ROMARB_SKIP_IDLE_EN
    logic [SB-1:0] ptr_q, ptr_d;

    // Pick the requester closest after the last granted channel.
    always_comb begin
        int best;
        int d;
        gnt_any = 1'b0;
        sel     = ptr_q;
        best    = NCH;
        d       = 0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.CHREQ[i]) begin
                d = (i + NCH - int'(ptr_q) - 1) % NCH;
                if (d < best) begin
                    best    = d;
                    sel     = SB'(i);
                    gnt_any = 1'b1;
                end
            end
        end
        if (RESET) gnt_any = 1'b0;
        ptr_d = gnt_any ? sel : ptr_q;
    end

    assign bus.PHASE = gnt_any ? sel : ptr_q;

    always_ff @(posedge CLK) begin
        if (RESET) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    logic [SB-1:0] phase_q, phase_d;

    always_comb begin
        sel     = phase_q;
        gnt_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(phase_q) == i) gnt_any = bus.CHREQ[i];
        end
        if (RESET) gnt_any = 1'b0;
        phase_d = (int'(phase_q) >= NCH - 1) ? '0 : phase_q + 1'b1;
    end

    assign bus.PHASE = phase_q;

    always_ff @(posedge CLK) begin
        if (RESET) phase_q <= '0;
        else       phase_q <= phase_d;
    end
`endif

    always_comb begin
        gnt   = '0;
        raddr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i) begin
                gnt[i] = gnt_any;
                raddr  = bus.CHAD[i*AW +: AW];
            end
        end
        tag_d.vld = gnt_any;
        tag_d.ch  = 3'(sel);
        val_d     = '0;
        dt_d      = dt_q;
        for (int i = 0; i < NCH; i++) begin
            if (tag_q.vld && int'(tag_q.ch) == i) begin
                val_d[i]                   = 1'b1;
                dt_d[chdt_lo(i, DWL) +: DWL] = rd;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q <= '0;
            val_q <= '0;
            dt_q  <= '0;
        end else begin
            tag_q <= tag_d;
            val_q <= val_d;
            dt_q  <= dt_d;
        end
    end

    assign bus.CHGNT = gnt;
    assign bus.CHVAL = val_q;
    assign bus.CHDT  = dt_q;

    logic [AW-1:0] waddr;
    assign waddr = AW'(bus.ROMAD >> LB);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic we;
        assign we = bus.ROMEN &&
                    ((bus.ROMAD & RAW'(LANES - 1)) == RAW'(l));
        chr_rom_lane #(.AW(AW)) u_lane (
            .clk   (CLK),
            .we    (we),
            .waddr (waddr),
            .wdata (bus.ROMDT),
            .raddr (raddr),
            .rdata (rd[l*8 +: 8])
        );
    end
endmodule

// File: tb/tb_chr_rom_arbiter.sv
// Directed bench for chr_rom_arbiter: NCH=2 main instance plus NCH=3 phase instance.
// Honours ROMARB_SKIP_IDLE_EN for slot-dependent expectations.
module tb_chr_rom_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chr_rom_arbiter_if #(.NCH(2), .AW(14), .LANES(4), .SB(1)) b0 ();
    chr_rom_arbiter_if #(.NCH(3), .AW(4),  .LANES(4), .SB(2)) b1 ();

    chr_rom_arbiter #(.NCH(2), .AW(14), .LANES(4), .SB(1)) u0 (
        .CLK(clk), .RESET(rst), .bus(b0));
    chr_rom_arbiter #(.NCH(3), .AW(4), .LANES(4), .SB(2)) u1 (
        .CLK(clk), .RESET(rst), .bus(b1));

    int total = 0;
    int bad   = 0;
    int ph0   = 0;
    int ptr0  = 0;
    int n0, n1, v0;
    int c3 [3];
    logic [1:0]  g1 = '0, g2 = '0, cg;
    logic [31:0] d1 = '0, d2 = '0;
    logic [63:0] edt = '0;
    logic [31:0] mdl [16];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mg(input logic [1:0] req, input int ph,
                                      input int ptr);
`ifdef ROMARB_SKIP_IDLE_EN
        for (int i = 1; i <= 2; i++) begin
            int j;
            j = (ptr + i) % 2;
            if (req[j]) return 2'(1 << j);
        end
        return 2'b00;
`else
        if (req[ph]) return 2'(1 << ph);
        return 2'b00;
`endif
    endfunction

    task automatic step();
        logic [31:0] dn;
        int ch;
        #1;
        cg = rst ? 2'b00 : mg(b0.CHREQ, ph0, ptr0);
        chk("gnt", 64'(b0.CHGNT), 64'(cg));
        if (b0.CHGNT[0]) n0++;
        if (b0.CHGNT[1]) n1++;
        ch = cg[1] ? 1 : 0;
`ifdef ROMARB_SKIP_IDLE_EN
        if (!rst) chk("phase", 64'(b0.PHASE), 64'((cg != 0) ? ch : ptr0));
`else
        if (!rst) chk("phase", 64'(b0.PHASE), 64'(ph0));
`endif
        dn = mdl[b0.CHAD[ch*14 +: 4]];
        @(posedge clk);
        if (rst) begin
            ph0 = 0; ptr0 = 0; g1 = '0; g2 = '0; edt = '0;
        end else begin
            g2 = g1; d2 = d1; g1 = cg; d1 = dn;
            ph0 = (ph0 + 1) % 2;
            if (cg != 0) ptr0 = ch;
            if (g2[0]) edt[31:0]  = d2;
            if (g2[1]) edt[63:32] = d2;
            if (b0.ROMEN)
                mdl[b0.ROMAD[5:2]][b0.ROMAD[1:0]*8 +: 8] = b0.ROMDT;
        end
        #1;
        chk("val", 64'(b0.CHVAL), 64'(g2));
        chk("dt", b0.CHDT, edt);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        b0.ROMEN = 1'b1;
        b0.ROMAD = 16'(a);
        b0.ROMDT = d;
        step();
        b0.ROMEN = 1'b0;
    endtask

    task automatic wait_slot0();
`ifndef ROMARB_SKIP_IDLE_EN
        for (int k = 0; k < 2 && ph0 != 0; k++) step();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        rst = 1'b1;
        b0.CHREQ = 2'b11; b0.CHAD = '0;
        b0.ROMEN = 1'b0; b0.ROMAD = '0; b0.ROMDT = '0;
        b1.CHREQ = 3'b111; b1.CHAD = '0;
        b1.ROMEN = 1'b0; b1.ROMAD = '0; b1.ROMDT = '0;
        n0 = 0; n1 = 0; v0 = 0;
        step();
        step();
        chk("rst_gnt", 64'(b0.CHGNT), 64'd0);
        chk("rst_val", 64'(b0.CHVAL), 64'd0);
        chk("rst_dt", b0.CHDT, 64'd0);
        chk("rst_phase", 64'(b0.PHASE), 64'd0);
        chk("rst_phase3", 64'(b1.PHASE), 64'd0);
        b0.CHREQ = 2'b00;
        rst = 1'b0;

        // NCH=3 slot sequence and fairness, all three requesting
        for (int i = 0; i < 3; i++) c3[i] = 0;
        for (int i = 0; i < 6; i++) begin
            int e;
`ifdef ROMARB_SKIP_IDLE_EN
            e = (i + 1) % 3;
`else
            e = i % 3;
`endif
            #1;
            chk("p3_phase", 64'(b1.PHASE), 64'(e));
            chk("p3_gnt", 64'(b1.CHGNT), 64'(1 << e));
            for (int c = 0; c < 3; c++) if (b1.CHGNT[c]) c3[c]++;
            step();
        end
        b1.CHREQ = 3'b000;
        for (int c = 0; c < 3; c++) chk("p3_fair", 64'(c3[c]), 64'd2);

        // Download words 0, 5, 9, 7
        for (int i = 0; i < 4; i++) begin
            wr(i,      8'(8'h11 * (i + 1)));
            wr(20 + i, 8'(8'h55 + 8'h11 * i));
            wr(36 + i, 8'(i + 1));
            wr(28 + i, 8'(8'hDD - 8'h11 * i));
        end

        // Single read of word 0 on ch0
        wait_slot0();
        b0.CHREQ = 2'b01; b0.CHAD = '0;
        step();
        b0.CHREQ = 2'b00;
        chk("t1_noval", 64'(b0.CHVAL), 64'd0);
        step();
        chk("t1_val", 64'(b0.CHVAL), 64'd1);
        chk("t1_dt", 64'(b0.CHDT[31:0]), 64'h44332211);
        step();
        chk("t1_pulse", 64'(b0.CHVAL), 64'd0);

        // Both channels requesting
        wait_slot0();
        b0.CHAD = {14'd9, 14'd5};
        b0.CHREQ = 2'b11;
        n0 = 0; n1 = 0;
        repeat (6) step();
        b0.CHREQ = 2'b00;
        step();
        step();
        chk("t2_n0", 64'(n0), 64'd3);
        chk("t2_n1", 64'(n1), 64'd3);
        chk("t2_dt", b0.CHDT, 64'h04030201_88776655);

        // Only ch1 requesting
        wait_slot0();
        b0.CHAD = {14'd9, 14'd0};
        b0.CHREQ = 2'b10;
        n0 = 0; n1 = 0; v0 = 0;
        repeat (4) begin
            step();
            if (b0.CHVAL[0]) v0++;
        end
        b0.CHREQ = 2'b00;
        repeat (2) begin
            step();
            if (b0.CHVAL[0]) v0++;
        end
        chk("t3_n0", 64'(n0), 64'd0);
`ifdef ROMARB_SKIP_IDLE_EN
        chk("t3_n1", 64'(n1), 64'd4);
`else
        chk("t3_n1", 64'(n1), 64'd2);
`endif
        chk("t3_val0", 64'(v0), 64'd0);

        // Same-cycle write and read of word 7
        wait_slot0();
        b0.CHREQ = 2'b01; b0.CHAD = {14'd0, 14'd7};
        b0.ROMEN = 1'b1; b0.ROMAD = 16'd28; b0.ROMDT = 8'h55;
        step();
        b0.ROMEN = 1'b0; b0.CHREQ = 2'b00;
        step();
        step();
        chk("t4_old", 64'(b0.CHDT[31:0]), 64'hAABBCCDD);
        wait_slot0();
        b0.CHREQ = 2'b01;
        step();
        b0.CHREQ = 2'b00;
        step();
        step();
        chk("t4_new", 64'(b0.CHDT[31:0]), 64'hAABBCC55);

        // Reset one cycle after a grant
        wait_slot0();
        b0.CHREQ = 2'b01; b0.CHAD = '0;
        step();
        b0.CHREQ = 2'b00;
        rst = 1'b1;
        step();
        chk("t5_val", 64'(b0.CHVAL), 64'd0);
        chk("t5_dt", b0.CHDT, 64'd0);
        chk("t5_phase", 64'(b0.PHASE), 64'd0);
        rst = 1'b0;
        step();
        chk("t5_noval", 64'(b0.CHVAL), 64'd0);
        wait_slot0();
        b0.CHREQ = 2'b01;
        step();
        b0.CHREQ = 2'b00;
        step();
        step();
        chk("t5_rom", 64'(b0.CHDT[31:0]), 64'h44332211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
